alu_issue_ctrl: RTL and testbench

- Multi-cycle decode/issue/writeback controller that sits directly upstream of the 16-bit ALU.
- Accepts one 16-bit instruction per valid/ready handshake and decodes it.
- Reads operands from an internal 8x16 register file and drives the ALU's a, b and alu_sel inputs.
- Captures the ALU's result and zero flag, then writes the result back to the register file.

---
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Decode/issue/writeback controller for a 16-bit ALU: fetches one instruction per handshake,
// reads operands from an 8-entry register file, drives the ALU and writes the result back.
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              ld_en,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              z_flag,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [2:0] OP_CMP = 3'd7;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       ir;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] regs [NREGS];

    logic [2:0] ir_op;
    logic [2:0] ir_rd;
    logic [2:0] ir_rs1;
    logic [2:0] ir_rs2;
    logic       ir_use_imm;
    logic [2:0] ir_imm3;

    assign ir_op      = ir[15:13];
    assign ir_rd      = ir[12:10];
    assign ir_rs1     = ir[9:7];
    assign ir_rs2     = ir[6:4];
    assign ir_use_imm = ir[3];
    assign ir_imm3    = ir[2:0];

    assign dbg_data = regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: IR latch, operand registers, result capture and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir      <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            res_q   <= '0;
            z_flag  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == WB);
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir <= instr_data;
                    end
                end
                DECODE: begin
                    alu_a   <= regs[ir_rs1];
                    alu_b   <= ir_use_imm ? {{(DATA_W-3){1'b0}}, ir_imm3} : regs[ir_rs2];
                    alu_sel <= ir_op;
                end
                EXEC: begin
                    res_q  <= alu_result;
                    z_flag <= alu_zero;
                end
                default: ;
            endcase
        end
    end

    // External loads only land in IDLE, so the WB write never collides with them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == IDLE && ld_en) begin
            regs[ld_addr] <= ld_data;
        end else if (state == WB && ir_op != OP_CMP) begin
            regs[ir_rd] <= res_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl: a behavioural model predicts each
// instruction's writeback and a monitor checks it when done pulses.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr_data = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        z_flag;
    logic        done;

    logic [2:0]  mon_addr = '0;
    logic [2:0]  sweep_addr = '0;
    logic        sweep_mode = 1'b0;
    assign dbg_addr = sweep_mode ? sweep_addr : mon_addr;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(16), .NREGS(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .z_flag(z_flag), .done(done)
    );

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ~a;
            3'd3:    return a << b;
            3'd4:    return a >> b;
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return a - b;
        endcase
    endfunction

    // Stand-in for the downstream ALU
    always_comb begin
        alu_result = alu_fn(alu_sel, alu_a, alu_b);
        alu_zero   = (alu_result == 16'd0);
    end

    typedef struct {
        int          cyc;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        z;
        logic [2:0]  rd;
        logic [15:0] rd_val;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mregs [8];
    int          busy = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: applies each accepted instruction to a register array immediately
    initial begin
        exp_t e;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 8; i++) mregs[i] = '0;
                exp_q.delete();
                busy = 0;
            end else begin
                cyc++;
                if (busy > 0) begin
                    busy--;
                end else begin
                    if (ld_en) mregs[ld_addr] = ld_data;
                    if (instr_valid) begin
                        e.cyc = cyc + 3;
                        e.op  = instr_data[15:13];
                        e.rd  = instr_data[12:10];
                        e.a   = mregs[instr_data[9:7]];
                        e.b   = instr_data[3] ? {13'd0, instr_data[2:0]} : mregs[instr_data[6:4]];
                        e.z   = (alu_fn(e.op, e.a, e.b) == 16'd0);
                        if (e.op != 3'd7) mregs[e.rd] = alu_fn(e.op, e.a, e.b);
                        e.rd_val = mregs[e.rd];
                        exp_q.push_back(e);
                        busy = 3;
                    end
                end
            end
        end
    end

    // Monitor: handshake readiness every cycle, full result check on each done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("instr_ready", {31'd0, instr_ready}, {31'd0, busy == 0});
            if (done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("alu_sel", {29'd0, alu_sel}, {29'd0, e.op});
                    chk("alu_a", {16'd0, alu_a}, {16'd0, e.a});
                    chk("alu_b", {16'd0, alu_b}, {16'd0, e.b});
                    chk("z_flag", {31'd0, z_flag}, {31'd0, e.z});
                    mon_addr = e.rd;
                    #1;
                    chk("rd_value", {16'd0, dbg_data}, {16'd0, e.rd_val});
                end
            end
        end
    end

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                       input int ui, input int imm);
        logic [15:0] w;
        w = {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], ui[0], imm[2:0]};
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            step();
            n++;
        end
        if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        wait_ready();
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] w, input logic le, input logic [2:0] la,
                         input logic [15:0] ld);
        wait_ready();
        instr_valid = 1'b1; instr_data = w;
        ld_en = le; ld_addr = la; ld_data = ld;
        step();
        instr_valid = 1'b0; ld_en = 1'b0;
        instr_data = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic sweep(input logic use_zero);
        sweep_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sweep_addr = 3'(i);
            #1;
            chk($sformatf("reg_r%0d", i), {16'd0, dbg_data},
                use_zero ? 32'd0 : {16'd0, mregs[i]});
        end
        sweep_mode = 1'b0;
    endtask

    initial begin
        int d0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_z", {31'd0, z_flag}, 32'd0);
        chk("reset_alu_a", {16'd0, alu_a}, 32'd0);
        chk("reset_alu_b", {16'd0, alu_b}, 32'd0);
        chk("reset_alu_sel", {29'd0, alu_sel}, 32'd0);
        sweep(1'b1);

        // Directed sequence
        load(3'd1, 16'd10);
        load(3'd2, 16'd5);
        load(3'd7, 16'hBEEF);
        issue(mk(0, 3, 1, 2, 0, 0), 1'b0, 3'd0, 16'd0);
        drain();
        issue(mk(1, 4, 1, 1, 0, 0), 1'b0, 3'd0, 16'd0);
        drain();
        issue(mk(0, 3, 1, 2, 0, 0), 1'b0, 3'd0, 16'd0);
        drain();
        issue(mk(3, 5, 1, 0, 1, 3), 1'b0, 3'd0, 16'd0);
        drain();
        issue(mk(4, 6, 5, 0, 1, 4), 1'b0, 3'd0, 16'd0);
        drain();
        issue(mk(7, 7, 1, 1, 0, 0), 1'b0, 3'd0, 16'd0);
        drain();
        chk("r5_shl", {16'd0, mregs[5]}, 32'd80);
        chk("r6_shr", {16'd0, mregs[6]}, 32'd5);
        chk("r7_cmp_untouched", {16'd0, mregs[7]}, 32'hBEEF);
        sweep(1'b0);

        // Back-to-back with instr_valid held high; a load during busy must be dropped
        d0 = done_count;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_data = (k == 0) ? mk(0, 0, 1, 2, 0, 0) :
                         (k == 1) ? mk(6, 6, 3, 0, 0, 0) : mk(5, 2, 6, 1, 0, 0);
            wait_ready();
            step();
            if (k == 0) begin
                ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'h1234;
                step();
                step();
                ld_en = 1'b0;
            end
        end
        instr_valid = 1'b0;
        drain();
        step();
        chk("stream_dones", done_count - d0, 3);
        sweep(1'b0);

        // Random instructions, sometimes with a simultaneous load
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) load(3'($urandom), 16'($urandom));
            issue(16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom_range(0, 3) * 16'd7));
            repeat ($urandom_range(0, 5)) step();
        end
        drain();
        sweep(1'b0);

        // Reset in EXEC discards the instruction and clears everything
        load(3'd1, 16'd10);
        load(3'd2, 16'd5);
        issue(mk(1, 4, 1, 1, 0, 0), 1'b0, 3'd0, 16'd0);
        drain();
        issue(mk(0, 3, 1, 2, 0, 0), 1'b0, 3'd0, 16'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("post_rst_z", {31'd0, z_flag}, 32'd0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        sweep(1'b1);
        repeat (5) step();
        sweep(1'b1);
        issue(mk(0, 3, 1, 2, 0, 0), 1'b0, 3'd0, 16'd0);
        drain();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
